// File: rtl/dram_lsu_if.sv
// Request/response bundle between the core memory stage and dram_lsu.
// Latency: none (wires only).
// Backpressure: req_ready_o from the LSU gates acceptance of req_valid_i; rsp side has no backpressure.
// Signals:
//   req_valid_i / req_ready_o   request handshake
//   req_we_i                    1 = store, 0 = load
//   req_addr_i                  byte address
//   req_size_i                  00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i              loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata_i                 right-justified store data
//   rsp_valid_o                 one-cycle completion pulse
//   rsp_rdata_o                 extended load data (0 for stores and errors)
//   rsp_err_o                   1 = access rejected, qualified by rsp_valid_o
interface dram_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [XLEN-1:0] req_addr_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  // Requester side (core memory stage).
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  // LSU side.
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dram_lsu.sv
// Data RAM with built-in load/store unit: byte/half/word loads and stores, lane steering, extension.
// Latency: accept->rsp 1 cycle (aligned or rejected), 2 cycles for a word-crossing access.
// Backpressure: one request outstanding; req_ready_o is high only while idle.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset (RAM contents are not reset)
//   bus      dram_lsu_if.slave: request handshake + one-cycle response pulse
// Build option: define DRAM_LSU_MISALIGN_EN to split word-crossing half/word accesses into
// two RAM beats; without it every misaligned half/word access is rejected and the second
// beat datapath is not built.
module dram_lsu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 10240,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  dram_lsu_if.slave bus
);

  localparam int NB        = XLEN / 8;     // byte lanes per word
  localparam int LAST_BYTE = DEPTH * 4 - 1; // highest legal byte address

`ifdef DRAM_LSU_MISALIGN_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_B1 = 2'd1, S_ERR = 2'd2, S_B2 = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_B1 = 2'd1, S_ERR = 2'd2} state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;

  // Request fields captured at accept.
  logic            r_we;
  logic            r_uns;
  logic [1:0]      r_size;
  logic [1:0]      r_off;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_wdat;
`ifdef DRAM_LSU_MISALIGN_EN
  logic            r_split;  // access spills into the next word
  logic [XLEN-1:0] r_lo;     // beat-1 read data held while beat 2 is read
`endif

  logic r_rsp_vld;
  logic r_rsp_err;
  logic w_rsp_vld_nxt;
  logic w_rsp_err_nxt;

  logic w_rdy;
  logic w_acc;

  assign w_rdy           = (r_state == S_IDLE);
  assign w_acc           = bus.req_valid_i & w_rdy;
  assign bus.req_ready_o = w_rdy;

  // ---------------------------------------------------------------------------
  // Accept-time legality checks
  // ---------------------------------------------------------------------------
  logic [2:0]  w_len_m1;
  logic        w_bad_size;
  logic [XLEN:0] w_end;
  logic        w_oob;
  logic        w_illegal;

  always_comb begin
    w_len_m1   = 3'd0;
    w_bad_size = 1'b0;
    case (bus.req_size_i)
      2'b00:   w_len_m1 = 3'd0;
      2'b01:   w_len_m1 = 3'd1;
      2'b10:   w_len_m1 = 3'd3;
      default: w_bad_size = 1'b1;
    endcase
  end

  // One bit wider than the address so a wrap past 2^XLEN shows up as out of range.
  assign w_end = {1'b0, bus.req_addr_i} + {{(XLEN-2){1'b0}}, w_len_m1};
  assign w_oob = (w_end > {1'b0, XLEN'(LAST_BYTE)});

`ifdef DRAM_LSU_MISALIGN_EN
  // Only accesses whose lanes run past byte 3 need a second beat; a half at
  // offset 1 still fits in one word.
  logic w_cross;
  assign w_cross   = ((bus.req_size_i == 2'b01) && (bus.req_addr_i[1:0] == 2'b11)) ||
                     ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
  assign w_illegal = w_bad_size | w_oob;
`else
  logic w_misal;
  assign w_misal   = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
                     ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
  assign w_illegal = w_bad_size | w_oob | w_misal;
`endif

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_off   <= 2'b00;
      r_idx   <= '0;
      r_wdat  <= '0;
`ifdef DRAM_LSU_MISALIGN_EN
      r_split <= 1'b0;
`endif
    end else if (w_acc) begin
      r_we    <= bus.req_we_i;
      r_uns   <= bus.req_unsigned_i;
      r_size  <= bus.req_size_i;
      r_off   <= bus.req_addr_i[1:0];
      r_idx   <= bus.req_addr_i[AW+1:2];
      r_wdat  <= bus.req_wdata_i;
`ifdef DRAM_LSU_MISALIGN_EN
      r_split <= w_cross;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_rsp_vld <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rsp_vld <= w_rsp_vld_nxt;
      r_rsp_err <= w_rsp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rsp_vld_nxt = 1'b0;
    w_rsp_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) w_state_nxt = w_illegal ? S_ERR : S_B1;
      end
      S_B1: begin
`ifdef DRAM_LSU_MISALIGN_EN
        if (r_split) begin
          w_state_nxt = S_B2;
        end else begin
          w_state_nxt   = S_IDLE;
          w_rsp_vld_nxt = 1'b1;
        end
`else
        w_state_nxt   = S_IDLE;
        w_rsp_vld_nxt = 1'b1;
`endif
      end
`ifdef DRAM_LSU_MISALIGN_EN
      S_B2: begin
        w_state_nxt   = S_IDLE;
        w_rsp_vld_nxt = 1'b1;
      end
`endif
      S_ERR: begin
        w_state_nxt   = S_IDLE;
        w_rsp_vld_nxt = 1'b1;
        w_rsp_err_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane steering for the RAM port
  // ---------------------------------------------------------------------------
  logic [NB-1:0]   w_be_base;
  logic [NB-1:0]   w_ram_be;
  logic [XLEN-1:0] w_ram_wd;
  logic [AW-1:0]   w_ram_idx;
  logic            w_ram_en;

  always_comb begin
    w_be_base = '1;
    case (r_size)
      2'b00:   w_be_base = NB'(1);
      2'b01:   w_be_base = NB'(3);
      default: w_be_base = '1;
    endcase
  end

`ifdef DRAM_LSU_MISALIGN_EN
  // Enables/data computed across two words; the upper half feeds beat 2.
  logic [2*NB-1:0]   w_be_all;
  logic [2*XLEN-1:0] w_wd_all;
  logic              w_beat2;

  assign w_be_all  = {{NB{1'b0}}, w_be_base} << r_off;
  assign w_wd_all  = {{XLEN{1'b0}}, r_wdat} << {r_off, 3'b000};
  assign w_beat2   = (r_state == S_B2);
  assign w_ram_be  = w_beat2 ? w_be_all[2*NB-1:NB]     : w_be_all[NB-1:0];
  assign w_ram_wd  = w_beat2 ? w_wd_all[2*XLEN-1:XLEN] : w_wd_all[XLEN-1:0];
  assign w_ram_idx = w_beat2 ? (r_idx + AW'(1))        : r_idx;
  assign w_ram_en  = (r_state == S_B1) || w_beat2;
`else
  // Misaligned accesses never reach B1 here, so nothing shifts out of lane 3.
  assign w_ram_be  = w_be_base << r_off;
  assign w_ram_wd  = r_wdat << {r_off, 3'b000};
  assign w_ram_idx = r_idx;
  assign w_ram_en  = (r_state == S_B1);
`endif

  // ---------------------------------------------------------------------------
  // Byte-enabled single-port RAM, synchronous read
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rd_dat;

  always_ff @(posedge clk_i) begin
    if (w_ram_en) begin
      for (int b = 0; b < NB; b++) begin
        if (r_we && w_ram_be[b]) r_mem[w_ram_idx][8*b +: 8] <= w_ram_wd[8*b +: 8];
      end
      r_rd_dat <= r_mem[w_ram_idx];
    end
  end

`ifdef DRAM_LSU_MISALIGN_EN
  // The edge that reads beat 2 into r_rd_dat moves beat 1 aside.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              r_lo <= '0;
    else if (r_state == S_B2)  r_lo <= r_rd_dat;
  end
`endif

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_ld_sh;
  logic [XLEN-1:0] w_ld_ext;

`ifdef DRAM_LSU_MISALIGN_EN
  logic [2*XLEN-1:0] w_ld_pair;
  assign w_ld_pair = r_split ? {r_rd_dat, r_lo} : {{XLEN{1'b0}}, r_rd_dat};
  assign w_ld_sh   = XLEN'(w_ld_pair >> {r_off, 3'b000});
`else
  assign w_ld_sh   = r_rd_dat >> {r_off, 3'b000};
`endif

  always_comb begin
    w_ld_ext = w_ld_sh;
    case (r_size)
      2'b00: w_ld_ext = r_uns ? {{(XLEN-8){1'b0}}, w_ld_sh[7:0]}
                              : {{(XLEN-8){w_ld_sh[7]}}, w_ld_sh[7:0]};
      2'b01: w_ld_ext = r_uns ? {{(XLEN-16){1'b0}}, w_ld_sh[15:0]}
                              : {{(XLEN-16){w_ld_sh[15]}}, w_ld_sh[15:0]};
      default: w_ld_ext = w_ld_sh;
    endcase
  end

  // Read data is valid during the rsp cycle (RAM idle), so the response is
  // formed combinationally from the read register and the captured fields.
  assign bus.rsp_valid_o = r_rsp_vld;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_rdata_o = (r_rsp_vld && !r_rsp_err && !r_we) ? w_ld_ext : '0;

endmodule

// File: tb/tb_dram_lsu.sv
`timescale 1ns/1ps
module tb_dram_lsu;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_lsu_if #(.XLEN(XLEN)) bus();

  dram_lsu #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Issue one request, wait for its response. lat = posedges from accept to
  // the rsp pulse; -1 if no response arrived within the budget.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic err);
    int waited;
    lat = -1; rd = '0; err = 1'b0;
    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = addr;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wdata;
    waited = 0;
    while (bus.req_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) begin
        lat = k;
        rd  = bus.rsp_rdata_o;
        err = bus.rsp_err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_in: got %b want 1", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid_in: got %b want 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata_o); end
    checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.rsp_err_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_out: got %b want 1", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid_out: got %b want 0", bus.rsp_valid_o); end
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, err);
    checks++; if (lat !== 1) begin errors++; $display("FAIL st_word_lat: got %0d want 1", lat); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL st_word_rsp: got err=%b rd=%h want 0/0", err, rd); end
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ld_word_lat: got %0d want 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_data: got %h want deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_word_err: got %b want 0", err); end
  endtask

  task automatic test_byte_half();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, err);
    do_req(1'b1, 32'h21, 2'b00, 1'b0, 32'h80, lat, rd, err);
    do_req(1'b0, 32'h21, 2'b00, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s: got %h want ffffff80", rd); end
    do_req(1'b0, 32'h21, 2'b00, 1'b1, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u: got %h want 00000080", rd); end
    do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h00008000) begin errors++; $display("FAIL ld_word_after_byte: got %h want 00008000", rd); end
    do_req(1'b0, 32'h20, 2'b01, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hFFFF8000) begin errors++; $display("FAIL ld_half_s0: got %h want ffff8000", rd); end
    do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'h1234BEEF, lat, rd, err);
    do_req(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL ld_half_s2: got %h want ffffbeef", rd); end
    do_req(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL ld_half_u2: got %h want 0000beef", rd); end
    do_req(1'b1, 32'h23, 2'b00, 1'b0, 32'hFFFFFF5A, lat, rd, err);
    do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h5AEF8000) begin errors++; $display("FAIL ld_word_lanes: got %h want 5aef8000", rd); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h44332211, lat, rd, err);
    do_req(1'b1, 32'h4, 2'b10, 1'b0, 32'h88776655, lat, rd, err);
`ifdef DRAM_LSU_MISALIGN_EN
    do_req(1'b0, 32'h3, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_ld_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'h77665544 || err !== 1'b0) begin errors++; $display("FAIL mis_ld_data: got %h err=%b want 77665544/0", rd, err); end
    do_req(1'b1, 32'h3, 2'b01, 1'b0, 32'h0000ABCD, lat, rd, err);
    checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL mis_st_rsp: got lat=%0d err=%b want 2/0", lat, err); end
    do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hCD332211) begin errors++; $display("FAIL mis_st_w0: got %h want cd332211", rd); end
    do_req(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h887766AB) begin errors++; $display("FAIL mis_st_w1: got %h want 887766ab", rd); end
    do_req(1'b0, 32'h3, 2'b01, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hFFFFABCD) begin errors++; $display("FAIL mis_ld_half: got %h want ffffabcd", rd); end
`else
    do_req(1'b0, 32'h1, 2'b01, 1'b0, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_half_err: got err=%b rd=%h want 1/0", err, rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_half_lat: got %0d want 1", lat); end
    do_req(1'b1, 32'h2, 2'b10, 1'b0, 32'hFFFFFFFF, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_st_err: got %b want 1", err); end
    do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL mis_st_w0: got %h want 44332211", rd); end
    do_req(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h88776655) begin errors++; $display("FAIL mis_st_w1: got %h want 88776655", rd); end
`endif
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 32'h3C, 2'b10, 1'b0, 32'h0F0F0F0F, lat, rd, err);
    do_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_word: got err=%b rd=%h want 1/0", err, rd); end
    do_req(1'b1, 32'h3F, 2'b01, 1'b0, 32'h00001234, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_half: got %b want 1", err); end
    do_req(1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0F0F0F0F || err !== 1'b0) begin errors++; $display("FAIL last_word: got %h err=%b want 0f0f0f0f/0", rd, err); end
    do_req(1'b0, 32'h3F, 2'b00, 1'b1, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0000000F || err !== 1'b0) begin errors++; $display("FAIL last_byte: got %h err=%b want 0000000f/0", rd, err); end
    do_req(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL size11: got err=%b lat=%0d want 1/1", err, lat); end
    do_req(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL addr_carry: got %b want 1", err); end
  endtask

  // Store then load accepted in the store's rsp cycle; valid held while busy.
  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 32'h14;
    bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_we_i = 1'b0; bus.req_wdata_i = 32'h0;
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready: got %b want 0", bus.req_ready_o); end
    @(negedge clk);
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL b2b_st_rsp: got v=%b e=%b want 1/0", bus.rsp_valid_o, bus.rsp_err_o); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_rsp: got %b want 1", bus.req_ready_o); end
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", bus.rsp_valid_o); end
    @(negedge clk);
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_ld: got v=%b rd=%h want 1/cafef00d", bus.rsp_valid_o, bus.rsp_rdata_o); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err;
    int seen;
`ifndef DRAM_LSU_MISALIGN_EN
    do_req(1'b1, 32'h30, 2'b10, 1'b0, 32'h11111111, lat, rd, err);
`endif
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
`ifdef DRAM_LSU_MISALIGN_EN
    bus.req_addr_i = 32'h3; bus.req_wdata_i = 32'hAABBCCDD;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
`else
    bus.req_addr_i = 32'h30; bus.req_wdata_i = 32'h22222222;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    #1 rst_n = 1'b0;
`endif
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) seen++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid_o === 1'b1) seen++;
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d pulses want 0", seen); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready_o); end
`ifdef DRAM_LSU_MISALIGN_EN
    do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hDD332211) begin errors++; $display("FAIL rstmid_w0: got %h want dd332211", rd); end
    do_req(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h887766AB) begin errors++; $display("FAIL rstmid_w1: got %h want 887766ab", rd); end
`else
    do_req(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h11111111 || lat !== 1) begin errors++; $display("FAIL rstmid_word: got %h lat=%0d want 11111111/1", rd, lat); end
`endif
  endtask

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = '0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_misalign();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_lsu.md
Name: dram_lsu

Overview:
- Parametrised data-memory block with a built-in load/store unit; successor to the fixed 40 KiB data RAM wrapper.
- Accepts one byte/half/word load or store per request over a valid/ready handshake.
- Generates byte enables from address and size, and sign- or zero-extends loads.
- Splits word-boundary-crossing (misaligned) accesses into two RAM beats and flags illegal accesses.
- Sits between the core's memory stage and an inferred single-clock, byte-enabled word RAM.

Parameters:
- XLEN, 32, data width; only 32 supported (4 byte lanes).
- DEPTH, 10240, RAM depth in XLEN-bit words.
- AW, $clog2(DEPTH), word-index width.

Ports:
- clk_i  in  1  clock, all logic on the rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  XLEN  byte address
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata_i  in  XLEN  store data, right-justified
- rsp_valid_o  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores and errors
- rsp_err_o  out  1  valid with rsp_valid_o; 1 = access rejected

Behaviour:
- Reset values (async assert, sync release): req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE. RAM contents are not reset.
- Handshake:
  - A request is accepted on a cycle where req_valid_i and req_ready_o are both 1; request fields are captured at that edge.
  - req_ready_o=1 only in IDLE; one outstanding request at a time.
- Error checks (done at accept; none of these ever write the RAM):
  - req_size_i=11, or end byte addr+bytes-1 falls beyond DEPTH*4-1 → ERR.
  - Misaligned access with the feature disabled → ERR.
  - End-address sum is computed XLEN+1 wide; carry-out counts as out of range.
- Byte enables:
  - byte: be = 1 << a[1:0].
  - half: be = 0011 << a[1:0], truncated to 4 bits; overflow lanes go to the next word.
  - word: 1111 on an aligned address.
- Store data is lane-shifted left by 8*a[1:0]; bits shifted past lane 3 feed beat 2.
- FSM states: IDLE, B1, B2, ERR.
  - IDLE→B1 on accept of a legal request. Beat 1 writes or reads word a[AW+1:2].
  - B1→IDLE if aligned; rsp_valid_o=1 the next cycle, so aligned load/store latency is 1 cycle from accept to rsp.
  - B1→B2 if misaligned; beat 2 accesses word+1 with the overflow enables/data; rsp follows B2, so latency is 2 cycles.
  - IDLE→ERR on an illegal request; ERR→IDLE after 1 cycle with rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
- Loads:
  - RAM read is synchronous.
  - Beat data are concatenated as {beat2, beat1} and shifted right by 8*a[1:0].
  - Result is masked to the access size, then extended per req_unsigned_i.
- Write-then-read: a load accepted the cycle after a store's rsp returns the stored value; RAM writes are committed before rsp.
- Reset mid-operation: the FSM returns to IDLE and no rsp is issued. A misaligned store cut between beats keeps its beat-1 bytes written and drops beat 2.
- req_valid_i while busy is ignored until req_ready_o=1. The requester must hold all request fields stable while req_valid_i=1.

Optional Feature:
- Macro: DRAM_LSU_MISALIGN_EN.
- Defined: misaligned half/word accesses take the two-beat split (B1→B2) as above.
- Undefined:
  - Any access with (half and a[0]=1) or (word and a[1:0]≠0) takes the ERR path with no write.
  - State B2 and the beat-2 datapath are not built.

Test Plan:
- Reset release → req_ready_o=1, rsp_valid_o=0. Store word 0xDEADBEEF @0x10, then load word @0x10 → rsp 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
- Store byte 0x80 @0x21 into a word preloaded with 0x00000000, then load byte signed @0x21 → 0xFFFFFF80; load byte unsigned @0x21 → 0x00000080; load word @0x20 → 0x00008000.
- With DRAM_LSU_MISALIGN_EN, preload word0=0x44332211, word1=0x88776655; load word @0x3 → rdata=0x77665544, rsp 2 cycles after accept. Store half 0xABCD @0x3 → word0=0xCD332211, word1=0x887766AB.
- Without the macro: load half @0x1 → rsp_err_o=1, rdata=0. Store word @0x2 with 0xFFFFFFFF → err=1 and words 0 and 1 unchanged.
- Out of range (DEPTH=16): load word @0x40 → err=1. Misaligned half @0x3F → err=1, word 15 unchanged. req_size_i=11 → err=1.
- Assert rst_n_i=0 during B2 of a misaligned store @0x3 → no rsp_valid_o; after release req_ready_o=1; word0 byte 3 updated, word1 unchanged.
